// File: rtl/dsa_interp_pkg.sv
// Shared types and helpers for the multi-lane pixel interpolator.
package dsa_interp_pkg;

    typedef enum logic {
        MODE_BILINEAR = 1'b0,
        MODE_NEAREST  = 1'b1
    } interp_mode_e;

    // Exact width of the bilinear accumulator: PIX_W + 2*FRAC_W + 2
    function automatic int acc_width(input int pix_w, input int frac_w);
        return pix_w + 2 * frac_w + 2;
    endfunction

    // Weight conditioning: clamp to 1.0 (S = 2^frac_w), then in nearest
    // mode snap to 0 or S. Exactly 0.5 rounds toward the higher-index
    // neighbour. Weights wider than 32 bits are not supported.
    function automatic logic [31:0] clamp_weight(input logic [31:0] w,
                                                 input interp_mode_e mode,
                                                 input int frac_w);
        logic [31:0] s;
        logic [31:0] c;
        s = 32'd1 << frac_w;
        c = (w > s) ? s : w;
        if (mode == MODE_NEAREST) begin
            c = (c >= (s >> 1)) ? s : 32'd0;
        end
        return c;
    endfunction

endpackage

// File: rtl/dsa_interp_lane.sv
// One interpolation lane: weight conditioning, horizontal blend, vertical
// blend with round-half-up. Each stage register loads only when the global
// enable is high and the data entering it is valid, so held or bubble
// cycles never disturb the registered pixel.
module dsa_interp_lane
    import dsa_interp_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int COORD_W = 16,
    parameter int FRAC_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    input  logic               s1_valid,
    input  logic               s2_valid,
    input  interp_mode_e       mode,
    input  logic [PIX_W-1:0]   p00,
    input  logic [PIX_W-1:0]   p01,
    input  logic [PIX_W-1:0]   p10,
    input  logic [PIX_W-1:0]   p11,
    input  logic [COORD_W-1:0] a,
    input  logic [COORD_W-1:0] b,
    output logic [PIX_W-1:0]   pix
);

    localparam int WW = FRAC_W + 1;                 // conditioned weight, 0..S
    localparam int TW = PIX_W + FRAC_W + 1;         // horizontal partial sum
    localparam int AW = acc_width(PIX_W, FRAC_W);   // full accumulator
    localparam logic [WW-1:0] ONE  = WW'(1) << FRAC_W;
    localparam logic [AW-1:0] HALF = AW'(1) << (2 * FRAC_W - 1);

    // Stage 1 registers
    logic [WW-1:0]    wa_reg, wna_reg, wb_reg, wnb_reg;
    logic [PIX_W-1:0] p00_reg, p01_reg, p10_reg, p11_reg;
    // Stage 2 registers
    logic [TW-1:0]    top_reg, bot_reg;
    logic [WW-1:0]    wb2_reg, wnb2_reg;
    // Stage 3 register
    logic [PIX_W-1:0] pix_reg;

    logic [WW-1:0]    wa_next, wb_next;
    logic [TW-1:0]    top_next, bot_next;
    logic [AW-1:0]    acc_next;
    logic [PIX_W-1:0] pix_next;

    // Combinational datapath for all three stages
    always_comb begin
        wa_next  = WW'(clamp_weight(32'(a), mode, FRAC_W));
        wb_next  = WW'(clamp_weight(32'(b), mode, FRAC_W));
        top_next = TW'(p00_reg) * TW'(wna_reg) + TW'(p01_reg) * TW'(wa_reg);
        bot_next = TW'(p10_reg) * TW'(wna_reg) + TW'(p11_reg) * TW'(wa_reg);
        acc_next = AW'(top_reg) * AW'(wnb2_reg) + AW'(bot_reg) * AW'(wb2_reg);
        pix_next = PIX_W'((acc_next + HALF) >> (2 * FRAC_W));
    end

    // S1: register conditioned weights, their complements and the neighbours
    always_ff @(posedge clk) begin
        if (rst) begin
            wa_reg  <= '0;
            wna_reg <= '0;
            wb_reg  <= '0;
            wnb_reg <= '0;
            p00_reg <= '0;
            p01_reg <= '0;
            p10_reg <= '0;
            p11_reg <= '0;
        end else if (en && in_valid) begin
            wa_reg  <= wa_next;
            wna_reg <= ONE - wa_next;
            wb_reg  <= wb_next;
            wnb_reg <= ONE - wb_next;
            p00_reg <= p00;
            p01_reg <= p01;
            p10_reg <= p10;
            p11_reg <= p11;
        end
    end

    // S2: horizontal blends of both rows, carry vertical weights along
    always_ff @(posedge clk) begin
        if (rst) begin
            top_reg  <= '0;
            bot_reg  <= '0;
            wb2_reg  <= '0;
            wnb2_reg <= '0;
        end else if (en && s1_valid) begin
            top_reg  <= top_next;
            bot_reg  <= bot_next;
            wb2_reg  <= wb_reg;
            wnb2_reg <= wnb_reg;
        end
    end

    // S3: vertical blend, round half up, register the output pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_reg <= '0;
        end else if (en && s2_valid) begin
            pix_reg <= pix_next;
        end
    end

    assign pix = pix_reg;

endmodule

// File: rtl/dsa_interp_simd.sv
// Multi-lane pipelined bilinear / nearest-neighbour interpolator top.
// Owns the valid/last pipeline, the global stall and the output counter;
// the per-lane arithmetic lives in dsa_interp_lane.
module dsa_interp_simd
    import dsa_interp_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int PIX_W   = 8,
    parameter int COORD_W = 16,
    parameter int FRAC_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_mode,
    input  logic                     in_last,
    input  logic [LANES*PIX_W-1:0]   in_p00,
    input  logic [LANES*PIX_W-1:0]   in_p01,
    input  logic [LANES*PIX_W-1:0]   in_p10,
    input  logic [LANES*PIX_W-1:0]   in_p11,
    input  logic [LANES*COORD_W-1:0] in_a,
    input  logic [LANES*COORD_W-1:0] in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*PIX_W-1:0]   out_pix,
    output logic                     out_last,
    output logic [31:0]              out_count
);

    logic        en;
    logic        s1_valid_reg, s2_valid_reg, out_valid_reg;
    logic        s1_last_reg, s2_last_reg, out_last_reg;
    logic [31:0] count_reg;

    // Whole pipeline advances together whenever the output slot can move
    assign en       = !out_valid_reg || out_ready;
    assign in_ready = en;

    // Valid and last bits travel alongside the lane data
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            s1_last_reg   <= 1'b0;
            s2_last_reg   <= 1'b0;
            out_last_reg  <= 1'b0;
        end else if (en) begin
            s1_valid_reg  <= in_valid;
            s2_valid_reg  <= s1_valid_reg;
            out_valid_reg <= s2_valid_reg;
            if (in_valid)     s1_last_reg  <= in_last;
            if (s1_valid_reg) s2_last_reg  <= s1_last_reg;
            if (s2_valid_reg) out_last_reg <= s2_last_reg;
        end
    end

    // Count accepted output vectors, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (out_valid_reg && out_ready) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            dsa_interp_lane #(
                .PIX_W   (PIX_W),
                .COORD_W (COORD_W),
                .FRAC_W  (FRAC_W)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .en       (en),
                .in_valid (in_valid),
                .s1_valid (s1_valid_reg),
                .s2_valid (s2_valid_reg),
                .mode     (interp_mode_e'(in_mode)),
                .p00      (in_p00[gi*PIX_W +: PIX_W]),
                .p01      (in_p01[gi*PIX_W +: PIX_W]),
                .p10      (in_p10[gi*PIX_W +: PIX_W]),
                .p11      (in_p11[gi*PIX_W +: PIX_W]),
                .a        (in_a[gi*COORD_W +: COORD_W]),
                .b        (in_b[gi*COORD_W +: COORD_W]),
                .pix      (out_pix[gi*PIX_W +: PIX_W])
            );
        end
    endgenerate

    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_count = count_reg;

endmodule
